// File: rtl/rank_scheduler_pkg.sv
// rtl/rank_scheduler_pkg.sv - shared types and wall-clock boundary constants
package rank_scheduler_pkg;

   typedef enum logic [1:0] {
      OP_IDLE  = 2'd0,
      OP_READ  = 2'd1,
      OP_WRITE = 2'd2
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GRANT,
      ST_CALC_REQ,
      ST_CALC_WAIT,
      ST_DONE,
      ST_ERR
   } state_t;

   localparam logic [4:0] HOUR_LAST   = 5'd23;
   localparam logic [5:0] MINUTE_LAST = 6'd59;
   localparam logic [5:0] SECOND_LAST = 6'd59;

endpackage

// File: rtl/rank_scheduler_rr_arbiter2.sv
// rtl/rank_scheduler_rr_arbiter2.sv - two-way round-robin arbiter
// Requester 0 has priority after reset; priority flips to the loser on each accepted pick.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       take,
   output logic       valid,
   output logic       pick
);

   logic ptr;

   always_comb begin
      valid = |req;
      if (req[0] && req[1]) pick = ptr;
      else                  pick = req[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              ptr <= 1'b0;
      else if (take && valid)  ptr <= ~pick;
   end

endmodule

// File: rtl/rank_scheduler.sv
// rtl/rank_scheduler.sv - hourly ranking scheduler with shared table-access arbitration
// Grants the traffic writer / ranked-table reader and launches a rank pass on each hour boundary.
module rank_scheduler
   import rank_scheduler_pkg::*;
#(
   parameter int TIMEOUT_CYC = 16,
   parameter int DAY_MAX     = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic [4:0] hour,
   input  logic [5:0] minute,
   input  logic [5:0] second,
   input  logic       upd_req,
   output logic       upd_gnt,
   input  logic       disp_req,
   output logic       disp_gnt,
   output op_t        op1,
   input  op_t        op2,
   output logic [2:0] day,
   output logic       busy,
   output logic       rank_done,
   output logic       timeout_err,
   output logic       overrun,
   input  logic       clr_err
);

   localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   state_t        state, state_nxt;
   logic          owner;  // 0: traffic writer, 1: ranked-table reader
   logic          calc_pend;
   logic [CW-1:0] cnt;
   logic          hour_b, day_b, consume, arb_take, arb_valid, arb_pick, owner_req;
   logic          timeout_set, overrun_set;

   assign hour_b      = tick && (minute == MINUTE_LAST) && (second == SECOND_LAST);
   assign day_b       = hour_b && (hour == HOUR_LAST);
   assign consume     = (state == ST_IDLE) && calc_pend;
   assign arb_take    = (state == ST_IDLE) && !calc_pend;
   assign owner_req   = owner ? disp_req : upd_req;
   assign timeout_set = (state == ST_CALC_WAIT) && (state_nxt == ST_ERR);
   // A boundary that lands on the cycle the pending pass is consumed is not lost work.
   assign overrun_set = hour_b && calc_pend && !consume;

   rr_arbiter2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   ({disp_req, upd_req}),
      .take  (arb_take),
      .valid (arb_valid),
      .pick  (arb_pick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (calc_pend)      state_nxt = ST_CALC_REQ;
            else if (arb_valid) state_nxt = ST_GRANT;
         end
         ST_GRANT:     if (!owner_req) state_nxt = ST_IDLE;
         ST_CALC_REQ:  state_nxt = ST_CALC_WAIT;
         ST_CALC_WAIT: begin
            if (op2 == OP_WRITE)              state_nxt = ST_DONE;
            else if (cnt == CW'(TIMEOUT_CYC - 1)) state_nxt = ST_ERR;
         end
         ST_DONE:      state_nxt = ST_IDLE;
         ST_ERR:       state_nxt = ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      op1       = OP_IDLE;
      upd_gnt   = 1'b0;
      disp_gnt  = 1'b0;
      busy      = (state != ST_IDLE);
      rank_done = 1'b0;
      case (state)
         ST_GRANT: begin
            upd_gnt  = !owner && upd_req;
            disp_gnt = owner && disp_req;
         end
         ST_CALC_REQ, ST_CALC_WAIT: op1 = OP_READ;
         ST_DONE:                   rank_done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner       <= 1'b0;
         calc_pend   <= 1'b0;
         cnt         <= '0;
         day         <= 3'd0;
         timeout_err <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (arb_take && arb_valid) owner <= arb_pick;

         if (hour_b)       calc_pend <= 1'b1;
         else if (consume) calc_pend <= 1'b0;

         if (state == ST_CALC_WAIT) cnt <= cnt + CW'(1);
         else                       cnt <= '0;

         if (day_b) day <= (day == 3'(DAY_MAX)) ? 3'd0 : day + 3'd1;

         if (timeout_set)  timeout_err <= 1'b1;
         else if (clr_err) timeout_err <= 1'b0;

         if (overrun_set)  overrun <= 1'b1;
         else if (clr_err) overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rank_scheduler.sv
// tb/tb_rank_scheduler.sv - self-checking bench for rank_scheduler
// A phase-level model is compared every cycle; directed scenarios add literal expectations.
module tb_rank_scheduler;
   import rank_scheduler_pkg::*;

   localparam int TO   = 16;
   localparam int DMAX = 4;
   localparam int P_IDLE = 0, P_GRANT = 1, P_CALC = 2, P_DONE = 3, P_ERR = 4;

   logic       clk = 1'b0, rst_n = 1'b0, tick = 1'b0, clr_err = 1'b0;
   logic       upd_req = 1'b0, disp_req = 1'b0;
   logic [4:0] hour = 5'd0;
   logic [5:0] minute = 6'd0, second = 6'd0;
   op_t        op2 = OP_IDLE;
   op_t        op1;
   logic       upd_gnt, disp_gnt, busy, rank_done, timeout_err, overrun;
   logic [2:0] day;

   int n_checks = 0, n_fail = 0;

   int m_phase = P_IDLE, m_owner = 0, m_upd_first = 1, m_pend = 0;
   int m_day = 0, m_terr = 0, m_ovr = 0, m_in_wait = 0, m_wcnt = 0;

   rank_scheduler #(.TIMEOUT_CYC(TO), .DAY_MAX(DMAX)) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .hour(hour), .minute(minute), .second(second),
      .upd_req(upd_req), .upd_gnt(upd_gnt), .disp_req(disp_req), .disp_gnt(disp_gnt),
      .op1(op1), .op2(op2), .day(day), .busy(busy), .rank_done(rank_done),
      .timeout_err(timeout_err), .overrun(overrun), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = P_IDLE; m_owner = 0; m_upd_first = 1; m_pend = 0;
      m_day = 0; m_terr = 0; m_ovr = 0; m_in_wait = 0; m_wcnt = 0;
   endtask

   // Advances the model by one clock using the inputs that the next rising edge will sample.
   task automatic model_step();
      int nphase, hb, consume, terr_set;
      hb       = int'(tick && minute == 6'd59 && second == 6'd59);
      consume  = int'(m_phase == P_IDLE && m_pend != 0);
      terr_set = 0;
      nphase   = m_phase;
      if (hb != 0 && m_pend != 0 && consume == 0) m_ovr = 1;
      else if (clr_err) m_ovr = 0;
      if (hb != 0 && hour == 5'd23) m_day = (m_day == DMAX) ? 0 : m_day + 1;
      case (m_phase)
         P_IDLE: begin
            if (m_pend != 0) begin
               nphase = P_CALC; m_in_wait = 0;
            end else if (upd_req || disp_req) begin
               nphase = P_GRANT;
               if (upd_req && disp_req) m_owner = (m_upd_first != 0) ? 0 : 1;
               else                     m_owner = disp_req ? 1 : 0;
               m_upd_first = (m_owner == 1) ? 1 : 0;
            end
         end
         P_GRANT: if (!((m_owner == 1) ? disp_req : upd_req)) nphase = P_IDLE;
         P_CALC: begin
            if (m_in_wait == 0) begin
               m_in_wait = 1; m_wcnt = 0;
            end else begin
               m_wcnt++;
               if (op2 == OP_WRITE) nphase = P_DONE;
               else if (m_wcnt == TO) begin nphase = P_ERR; terr_set = 1; end
            end
         end
         default: nphase = P_IDLE;
      endcase
      if (terr_set != 0) m_terr = 1;
      else if (clr_err) m_terr = 0;
      if (hb != 0) m_pend = 1;
      else if (consume != 0) m_pend = 0;
      m_phase = nphase;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) model_reset();
         check("op1", int'(op1), (m_phase == P_CALC) ? int'(OP_READ) : int'(OP_IDLE));
         check("busy", int'(busy), int'(m_phase != P_IDLE));
         check("rank_done", int'(rank_done), int'(m_phase == P_DONE));
         check("upd_gnt", int'(upd_gnt), int'(m_phase == P_GRANT && m_owner == 0 && upd_req));
         check("disp_gnt", int'(disp_gnt), int'(m_phase == P_GRANT && m_owner == 1 && disp_req));
         check("day", int'(day), m_day);
         check("timeout_err", int'(timeout_err), m_terr);
         check("overrun", int'(overrun), m_ovr);
         if (rst_n) model_step();
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tick_at(input int h, input int m, input int s);
      hour = 5'(h); minute = 6'(m); second = 6'(s);
      tick = 1'b1; cyc(1); tick = 1'b0;
   endtask

   task automatic wait_for_read(input int budget, input string name);
      int k = 0;
      while (op1 != OP_READ && k < budget) begin cyc(1); k++; end
      check(name, int'(op1 == OP_READ), 1);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int k = 0;
      while (busy && k < budget) begin cyc(1); k++; end
      check(name, int'(busy), 0);
   endtask

   task automatic run_pass(input int h);
      tick_at(h, 59, 59);
      wait_for_read(4, "pass_read");
      cyc(1);
      op2 = OP_WRITE; cyc(1); op2 = OP_IDLE;
      wait_idle(6, "pass_idle");
   endtask

   initial begin
      int seq[3];
      int k, n;

      cyc(2);
      check("rst_day", int'(day), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_op1", int'(op1), int'(OP_IDLE));
      check("rst_flags", int'(timeout_err | overrun | rank_done | upd_gnt | disp_gnt), 0);
      rst_n = 1'b1;
      cyc(2);

      // Basic ranking pass launched from 10:59:59.
      tick_at(10, 59, 59);
      check("read_not_yet", int'(op1), int'(OP_IDLE));
      cyc(1);
      check("read_2cyc", int'(op1), int'(OP_READ));
      cyc(3);
      op2 = OP_WRITE; cyc(1); op2 = OP_IDLE;
      check("done_pulse", int'(rank_done), 1);
      check("done_op1", int'(op1), int'(OP_IDLE));
      cyc(1);
      check("done_one_cycle", int'(rank_done), 0);
      check("done_busy", int'(busy), 0);
      cyc(2);

      // Both requesters held; each drops after four granted cycles.
      upd_req = 1'b1; disp_req = 1'b1;
      for (int g = 0; g < 3; g++) begin
         k = 0;
         while (!(upd_gnt || disp_gnt) && k < 8) begin cyc(1); k++; end
         seq[g] = upd_gnt ? 1 : (disp_gnt ? 2 : 0);
         cyc(3);
         if (seq[g] == 1)      upd_req = 1'b0;
         else if (seq[g] == 2) disp_req = 1'b0;
         else begin upd_req = 1'b0; disp_req = 1'b0; end
         cyc(1);
         if (g < 2) begin upd_req = 1'b1; disp_req = 1'b1; end
      end
      upd_req = 1'b0; disp_req = 1'b0;
      check("rr_first_upd", seq[0], 1);
      check("rr_second_disp", seq[1], 2);
      check("rr_third_upd", seq[2], 1);
      cyc(2);

      // Hour boundary during an active reader grant must not preempt it.
      disp_req = 1'b1;
      k = 0;
      while (!disp_gnt && k < 4) begin cyc(1); k++; end
      check("disp_granted", int'(disp_gnt), 1);
      tick_at(13, 59, 59);
      for (int i = 0; i < 5; i++) begin
         check("no_preempt", int'(op1 == OP_READ), 0);
         cyc(1);
      end
      disp_req = 1'b0;
      wait_for_read(4, "deferred_read");
      cyc(2);
      op2 = OP_WRITE; cyc(1); op2 = OP_IDLE;
      wait_idle(6, "deferred_idle");

      // Calculator never answers: timeout after TO wait cycles.
      tick_at(10, 59, 59);
      wait_for_read(4, "timeout_read");
      n = 0;
      while (op1 == OP_READ && n < 40) begin n++; cyc(1); end
      check("read_cycles", n, TO + 1);
      check("timeout_set", int'(timeout_err), 1);
      check("err_busy", int'(busy), 1);
      cyc(4);
      check("timeout_sticky", int'(timeout_err), 1);
      clr_err = 1'b1; cyc(1); clr_err = 1'b0;
      check("timeout_cleared", int'(timeout_err), 0);
      cyc(2);

      // Day wrap and overrun.
      for (int d = 0; d < DMAX; d++) run_pass(23);
      check("day_at_max", int'(day), DMAX);
      tick_at(23, 59, 59);
      check("day_wrap", int'(day), 0);
      wait_for_read(4, "wrap_read");
      hour = 5'd10; tick = 1'b1;
      cyc(1);
      check("no_overrun_yet", int'(overrun), 0);
      clr_err = 1'b1;
      cyc(1);
      tick = 1'b0; clr_err = 1'b0;
      check("overrun_set_wins", int'(overrun), 1);
      op2 = OP_WRITE; cyc(1); op2 = OP_IDLE;
      wait_for_read(4, "pending_resumes");
      cyc(1);
      op2 = OP_WRITE; cyc(1); op2 = OP_IDLE;
      wait_idle(6, "overrun_idle");
      clr_err = 1'b1; cyc(1); clr_err = 1'b0;
      check("overrun_cleared", int'(overrun), 0);

      // Reset in the middle of a wait abandons the pass.
      tick_at(10, 59, 59);
      wait_for_read(4, "rst_pass_read");
      cyc(5);
      rst_n = 1'b0;
      #1;
      check("rst_mid_op1", int'(op1), int'(OP_IDLE));
      check("rst_mid_busy", int'(busy), 0);
      check("rst_mid_terr", int'(timeout_err), 0);
      cyc(2);
      rst_n = 1'b1;
      cyc(TO + 6);
      check("rst_no_terr", int'(timeout_err), 0);
      check("rst_stays_idle", int'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
